// File: rtl/omsp_spm_cmd_seq_if.sv
// Bundle of the command, SPM-update and key-stream signals shared by the
// sequencer (slave) and its environment (master).
interface omsp_spm_cmd_seq_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_protect;
  logic        update_spm;
  logic        enable_spm;
  logic        violation;
  logic        kw_valid;
  logic [15:0] kw_data;
  logic        kw_ready;
  logic        write_key;
  logic [15:0] key_in;
  logic        busy;
  logic        done;
  logic        ok;

  modport slave (
    input  cmd_valid, cmd_protect, violation, kw_valid, kw_data,
    output cmd_ready, update_spm, enable_spm, kw_ready, write_key, key_in,
           busy, done, ok
  );

  modport master (
    output cmd_valid, cmd_protect, violation, kw_valid, kw_data,
    input  cmd_ready, update_spm, enable_spm, kw_ready, write_key, key_in,
           busy, done, ok
  );
endinterface

// File: rtl/omsp_spm_cmd_seq.sv
// SPM command sequencer: issues the update_spm/enable_spm strobe for a
// protect/unprotect request and streams the module key into the SPM array.
module omsp_spm_cmd_seq #(
  parameter int KEY_WORDS = 8,
  parameter int TIMEOUT   = 255
) (
  input logic               mclk,
  input logic               puc_rst,
  omsp_spm_cmd_seq_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_UPDATE = 2'd1,
    ST_KEY    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam logic [3:0]  LAST_WORD = 4'(KEY_WORDS - 1);
  localparam logic [15:0] TMO_LAST  = 16'(TIMEOUT - 1);

  state_t      state_r;
  logic        op_r;
  logic [3:0]  wcnt_r;
  logic [15:0] tmo_r;
  logic [15:0] key_hold_r;
  logic        cmd_ready_r;
  logic        update_r;
  logic        enable_r;
  logic        kw_ready_r;
  logic        busy_r;
  logic        done_r;
  logic        ok_r;
  logic        write_key_s;

  // Key words pass straight through with zero latency while kw_ready is up.
  assign write_key_s    = kw_ready_r & bus.kw_valid;
  assign bus.write_key  = write_key_s;
  assign bus.key_in     = write_key_s ? bus.kw_data : key_hold_r;
  assign bus.cmd_ready  = cmd_ready_r;
  assign bus.update_spm = update_r;
  assign bus.enable_spm = enable_r;
  assign bus.kw_ready   = kw_ready_r;
  assign bus.busy       = busy_r;
  assign bus.done       = done_r;
  assign bus.ok         = ok_r;

  // Sequencer state and registered outputs; each output holds its value for the state being entered.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      state_r     <= ST_IDLE;
      op_r        <= 1'b0;
      wcnt_r      <= 4'd0;
      tmo_r       <= 16'd0;
      key_hold_r  <= 16'd0;
      cmd_ready_r <= 1'b1;
      update_r    <= 1'b0;
      enable_r    <= 1'b0;
      kw_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      ok_r        <= 1'b0;
    end else begin
      update_r <= 1'b0;
      enable_r <= 1'b0;
      done_r   <= 1'b0;
      if (write_key_s) begin
        key_hold_r <= bus.kw_data;
      end
      case (state_r)
        ST_IDLE: begin
          if (bus.cmd_valid && cmd_ready_r) begin
            op_r        <= bus.cmd_protect;
            busy_r      <= 1'b1;
            ok_r        <= 1'b0;
            cmd_ready_r <= 1'b0;
            update_r    <= 1'b1;
            enable_r    <= bus.cmd_protect;
            state_r     <= ST_UPDATE;
          end else begin
            cmd_ready_r <= 1'b1;
          end
        end
        ST_UPDATE: begin
          if (op_r && !bus.violation) begin
            wcnt_r     <= 4'd0;
            tmo_r      <= 16'd0;
            kw_ready_r <= 1'b1;
            state_r    <= ST_KEY;
          end else begin
            // A refused protect reports failure; unprotect ignores violation.
            ok_r    <= !op_r;
            done_r  <= 1'b1;
            state_r <= ST_DONE;
          end
        end
        ST_KEY: begin
          if (bus.kw_valid) begin
            wcnt_r <= wcnt_r + 4'd1;
            tmo_r  <= 16'd0;
            if (wcnt_r == LAST_WORD) begin
              ok_r       <= 1'b1;
              kw_ready_r <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              kw_ready_r <= 1'b1;
            end
          end else begin
            if (tmo_r != 16'hFFFF) begin
              tmo_r <= tmo_r + 16'd1;
            end else begin
              tmo_r <= tmo_r;
            end
            // Abort on the idle cycle that brings the idle count up to TIMEOUT.
            if (tmo_r >= TMO_LAST) begin
              ok_r       <= 1'b0;
              kw_ready_r <= 1'b0;
              done_r     <= 1'b1;
              state_r    <= ST_DONE;
            end else begin
              kw_ready_r <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          state_r     <= ST_IDLE;
        end
        default: begin
          busy_r      <= 1'b0;
          cmd_ready_r <= 1'b1;
          kw_ready_r  <= 1'b0;
          state_r     <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_omsp_spm_cmd_seq.sv
// Directed bench for omsp_spm_cmd_seq with KEY_WORDS=8 and TIMEOUT=4.
module tb_omsp_spm_cmd_seq;

  logic mclk = 1'b0;
  logic puc_rst;
  int   n_cmp = 0;
  int   n_err = 0;

  omsp_spm_cmd_seq_if sif ();

  omsp_spm_cmd_seq #(.KEY_WORDS(8), .TIMEOUT(4)) dut (
    .mclk    (mclk),
    .puc_rst (puc_rst),
    .bus     (sif)
  );

  always #5 mclk = ~mclk;

  logic [15:0] wr_q[$];
  int          upd_cnt;
  logic        upd_en;
  int          kwr_cnt;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge mclk);
    #1;
  endtask

  // Issue one command; vmask bit (c-1) is kw_valid in cycle c after accept.
  task automatic do_cmd(input logic prot, input logic viol, input logic [31:0] vmask,
                        output int done_cyc, output logic ok_v);
    int       wi;
    logic [15:0] d;
    wi = 0;
    wr_q.delete();
    upd_cnt = 0;
    upd_en  = 1'b0;
    kwr_cnt = 0;
    done_cyc = -1;
    ok_v = 1'bx;
    sif.cmd_valid   = 1'b1;
    sif.cmd_protect = prot;
    #1;
    chk("accept_ready", 32'(sif.cmd_ready), 32'd1);
    next_cycle();
    sif.cmd_valid = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      d = 16'h1111 * 16'(wi + 1);
      sif.violation = viol;
      sif.kw_valid  = vmask[c-1];
      sif.kw_data   = d;
      sif.cmd_valid = 1'b1;
      #1;
      if (c == 1) begin
        chk("busy_upd", 32'(sif.busy), 32'd1);
        chk("ready_upd", 32'(sif.cmd_ready), 32'd0);
      end
      if (sif.update_spm) begin
        upd_cnt++;
        upd_en = sif.enable_spm;
      end
      if (sif.kw_ready) kwr_cnt++;
      if (sif.write_key) begin
        wr_q.push_back(sif.key_in);
        wi++;
      end
      if (sif.done) begin
        done_cyc = c;
        ok_v = sif.ok;
        break;
      end
      next_cycle();
    end
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    sif.cmd_valid = 1'b0;
    sif.kw_valid  = 1'b0;
    next_cycle();
    chk("idle_busy", 32'(sif.busy), 32'd0);
    chk("idle_ready", 32'(sif.cmd_ready), 32'd1);
    chk("ok_held", 32'(sif.ok), 32'(ok_v));
  endtask

  int   dc;
  logic okv;

  initial begin
    puc_rst         = 1'b1;
    sif.cmd_valid   = 1'b0;
    sif.cmd_protect = 1'b0;
    sif.violation   = 1'b0;
    sif.kw_valid    = 1'b1;
    sif.kw_data     = 16'hABCD;
    next_cycle();
    next_cycle();
    puc_rst = 1'b0;
    #1;
    chk("rst_ready", 32'(sif.cmd_ready), 32'd1);
    chk("rst_upd", 32'(sif.update_spm), 32'd0);
    chk("rst_en", 32'(sif.enable_spm), 32'd0);
    chk("rst_kwr", 32'(sif.kw_ready), 32'd0);
    chk("rst_wk", 32'(sif.write_key), 32'd0);
    chk("rst_key", 32'(sif.key_in), 32'd0);
    chk("rst_busy", 32'(sif.busy), 32'd0);
    chk("rst_done", 32'(sif.done), 32'd0);
    chk("rst_ok", 32'(sif.ok), 32'd0);
    next_cycle();
    sif.kw_valid = 1'b0;

    // Protect, no violation, key words streamed back-to-back.
    do_cmd(1'b1, 1'b0, 32'hFFFF_FFFF, dc, okv);
    chk("p_done_cyc", 32'(dc), 32'd10);
    chk("p_ok", 32'(okv), 32'd1);
    chk("p_upd_cnt", 32'(upd_cnt), 32'd1);
    chk("p_upd_en", 32'(upd_en), 32'd1);
    chk("p_kwr_cnt", 32'(kwr_cnt), 32'd8);
    chk("p_nwr", 32'(wr_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wr_q.size()) chk("p_word", 32'(wr_q[i]), 32'(16'h1111 * 16'(i + 1)));
    end
    chk("p_key_hold", 32'(sif.key_in), 32'h8888);

    // Protect refused by violation.
    do_cmd(1'b1, 1'b1, 32'hFFFF_FFFF, dc, okv);
    chk("pv_done_cyc", 32'(dc), 32'd2);
    chk("pv_ok", 32'(okv), 32'd0);
    chk("pv_upd_en", 32'(upd_en), 32'd1);
    chk("pv_kwr", 32'(kwr_cnt), 32'd0);
    chk("pv_nwr", 32'(wr_q.size()), 32'd0);

    // Unprotect ignores violation.
    do_cmd(1'b0, 1'b1, 32'hFFFF_FFFF, dc, okv);
    chk("u_done_cyc", 32'(dc), 32'd2);
    chk("u_ok", 32'(okv), 32'd1);
    chk("u_upd_cnt", 32'(upd_cnt), 32'd1);
    chk("u_upd_en", 32'(upd_en), 32'd0);
    chk("u_nwr", 32'(wr_q.size()), 32'd0);

    // Three words then silence: aborts after 4 idle cycles (words in c2..c4, idle c5..c8).
    do_cmd(1'b1, 1'b0, 32'h0000_000F, dc, okv);
    chk("t_done_cyc", 32'(dc), 32'd9);
    chk("t_ok", 32'(okv), 32'd0);
    chk("t_nwr", 32'(wr_q.size()), 32'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_q.size()) chk("t_word", 32'(wr_q[i]), 32'(16'h1111 * 16'(i + 1)));
    end
    chk("t_key_hold", 32'(sif.key_in), 32'h3333);

    // Toggling valid plus a 3-cycle gap; idle count must clear on every word.
    do_cmd(1'b1, 1'b0, 32'hFFFF_78AB, dc, okv);
    chk("g_done_cyc", 32'(dc), 32'd16);
    chk("g_ok", 32'(okv), 32'd1);
    chk("g_nwr", 32'(wr_q.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      if (i < wr_q.size()) chk("g_word", 32'(wr_q[i]), 32'(16'h1111 * 16'(i + 1)));
    end

    // Reset after the 4th key word.
    sif.cmd_valid   = 1'b1;
    sif.cmd_protect = 1'b1;
    sif.violation   = 1'b0;
    next_cycle();
    sif.cmd_valid = 1'b0;
    sif.kw_valid  = 1'b1;
    okv = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      sif.kw_data = 16'h1111 * 16'(c - 1);
      #1;
      if (sif.write_key) okv = 1'b1;
      next_cycle();
    end
    sif.kw_valid = 1'b0;
    puc_rst = 1'b1;
    next_cycle();
    puc_rst = 1'b0;
    sif.kw_valid = 1'b1;
    sif.kw_data  = 16'h5555;
    #1;
    chk("r_words_before", 32'(okv), 32'd1);
    chk("r_ready", 32'(sif.cmd_ready), 32'd1);
    chk("r_busy", 32'(sif.busy), 32'd0);
    chk("r_kwr", 32'(sif.kw_ready), 32'd0);
    chk("r_wk", 32'(sif.write_key), 32'd0);
    chk("r_upd", 32'(sif.update_spm), 32'd0);
    okv = 1'b0;
    for (int c = 0; c < 6; c++) begin
      next_cycle();
      if (sif.done || sif.write_key) okv = 1'b1;
    end
    chk("r_no_done", 32'(okv), 32'd0);
    sif.kw_valid = 1'b0;
    do_cmd(1'b0, 1'b0, 32'h0, dc, okv);
    chk("r_new_done_cyc", 32'(dc), 32'd2);
    chk("r_new_ok", 32'(okv), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
